// File: rtl/mac_operand_splitter_pkg.sv
// Shared types for the MAC operand splitter: control/flag structs, FSM state enum
// and the default maximum job length.
package mac_operand_splitter_pkg;

  localparam int unsigned MAC_CNT_LEN = 16;
  localparam int unsigned MAC_CW      = $clog2(MAC_CNT_LEN) + 1;

  typedef struct packed {
    logic              clear;
    logic              enable;
    logic              start;
    logic              simple_mul;
    logic [MAC_CW-1:0] len;
  } ctrl_splitter_t;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic [MAC_CW-1:0] cnt;
    logic [31:0]       stall_cnt;
  } flags_splitter_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    C_PHASE = 3'd1,
    A_PHASE = 3'd2,
    B_PHASE = 3'd3,
    DONE    = 3'd4
  } splitter_state_t;

endpackage

// File: rtl/mac_operand_splitter.sv
// Splits one interleaved operand stream into the MAC a/b/c streams (streams flattened
// to valid/ready/data/strb). Optional stall counter: MAC_SPLITTER_STALL_CNT_EN.
//
// Handshake: a word moves on any stream in a cycle where valid & ready are both high;
// a source never lowers valid or changes data/strb before that cycle, and no valid
// here is derived from a ready.
module mac_operand_splitter
  import mac_operand_splitter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_LEN    = MAC_CNT_LEN
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_mode_i,
  input  logic                    in_i_valid,
  output logic                    in_i_ready,
  input  logic [DATA_WIDTH-1:0]   in_i_data,
  input  logic [DATA_WIDTH/8-1:0] in_i_strb,
  output logic                    a_o_valid,
  input  logic                    a_o_ready,
  output logic [DATA_WIDTH-1:0]   a_o_data,
  output logic [DATA_WIDTH/8-1:0] a_o_strb,
  output logic                    b_o_valid,
  input  logic                    b_o_ready,
  output logic [DATA_WIDTH-1:0]   b_o_data,
  output logic [DATA_WIDTH/8-1:0] b_o_strb,
  output logic                    c_o_valid,
  input  logic                    c_o_ready,
  output logic [DATA_WIDTH-1:0]   c_o_data,
  output logic [DATA_WIDTH/8-1:0] c_o_strb,
  input  ctrl_splitter_t          ctrl_i,
  output flags_splitter_t         flags_o,
  output splitter_state_t         dbg_state_o
);

  localparam int unsigned   CW      = MAC_CW;
  localparam int unsigned   SW      = DATA_WIDTH / 8;
  localparam logic [CW-1:0] LEN_MAX = CW'(CNT_LEN);

  splitter_state_t       r_state;
  logic [CW-1:0]         r_len;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_a;
  logic [SW-1:0]         r_a_strb;

  logic          w_en;
  logic          w_hs;
  logic          w_ab_ready;
  logic [CW-1:0] w_len_req;
  logic [CW-1:0] w_cnt_inc;
  logic [31:0]   w_stall_cnt;
  logic          w_unused;

  assign w_unused   = test_mode_i;
  assign w_en       = ctrl_i.enable;
  assign w_ab_ready = a_o_ready & b_o_ready;
  assign w_hs       = in_i_valid & in_i_ready;
  assign w_cnt_inc  = r_cnt + CW'(1);
  // Requests longer than the counter can represent are clamped, so cnt never wraps.
  assign w_len_req  = (ctrl_i.len > LEN_MAX) ? LEN_MAX : ctrl_i.len;

  always_comb begin
    in_i_ready = 1'b0;
    a_o_valid  = 1'b0;
    b_o_valid  = 1'b0;
    c_o_valid  = 1'b0;
    if (w_en) begin
      case (r_state)
        C_PHASE: begin
          c_o_valid  = in_i_valid;
          in_i_ready = c_o_ready;
        end
        A_PHASE: in_i_ready = 1'b1;
        B_PHASE: begin
          a_o_valid  = in_i_valid;
          b_o_valid  = in_i_valid;
          in_i_ready = w_ab_ready;
        end
        default: ;
      endcase
    end
  end

  assign c_o_data = in_i_data;
  assign c_o_strb = in_i_strb;
  assign a_o_data = r_a;
  assign a_o_strb = r_a_strb;
  assign b_o_data = in_i_data;
  assign b_o_strb = in_i_strb;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_a_strb <= '0;
    end else if (ctrl_i.clear) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_a_strb <= '0;
    end else if (w_en) begin
      case (r_state)
        IDLE: begin
          if (ctrl_i.start) begin
            r_len <= w_len_req;
            r_cnt <= '0;
            if (w_len_req == '0)        r_state <= DONE;
            else if (ctrl_i.simple_mul) r_state <= A_PHASE;
            else                        r_state <= C_PHASE;
          end
        end
        C_PHASE: if (w_hs) r_state <= A_PHASE;
        A_PHASE: begin
          if (w_hs) begin
            r_a      <= in_i_data;
            r_a_strb <= in_i_strb;
            r_state  <= B_PHASE;
          end
        end
        B_PHASE: begin
          if (w_hs) begin
            r_cnt   <= w_cnt_inc;
            r_state <= (w_cnt_inc == r_len) ? DONE : A_PHASE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MAC_SPLITTER_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Counts cycles a ready pair was held back by the engine; saturates instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (ctrl_i.clear) begin
      r_stall_cnt <= '0;
    end else if (w_en && (r_state == IDLE) && ctrl_i.start) begin
      r_stall_cnt <= '0;
    end else if (w_en && (r_state == B_PHASE) && in_i_valid && !w_ab_ready &&
                 (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign w_stall_cnt = r_stall_cnt;
`else
  assign w_stall_cnt = '0;
`endif

  assign flags_o.busy      = (r_state != IDLE);
  assign flags_o.done      = (r_state == DONE);
  assign flags_o.cnt       = r_cnt;
  assign flags_o.stall_cnt = w_stall_cnt;
  assign dbg_state_o       = r_state;

`ifndef SYNTHESIS
  a_ab_valid_equal : assert property (@(posedge clk_i) disable iff (!rst_ni)
    a_o_valid == b_o_valid);

  a_ab_data_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (a_o_valid && !w_ab_ready && w_en && !ctrl_i.clear) |=>
      (!a_o_valid || ($stable(a_o_data) && $stable(b_o_data))));

  a_c_data_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (c_o_valid && !c_o_ready && w_en && !ctrl_i.clear) |=>
      (!c_o_valid || $stable(c_o_data)));

  a_ab_valid_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (a_o_valid && !w_ab_ready && w_en && !ctrl_i.clear) |=> (a_o_valid || !ctrl_i.enable));

  a_c_valid_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (c_o_valid && !c_o_ready && w_en && !ctrl_i.clear) |=> (c_o_valid || !ctrl_i.enable));
`endif

endmodule

// File: tb/tb_mac_operand_splitter.sv
// Directed bench for mac_operand_splitter: stimulus pushes expected c words and (a,b)
// pairs into queues, a negedge monitor pops and compares on every output handshake.
module tb_mac_operand_splitter;
  import mac_operand_splitter_pkg::*;

  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            test_mode_i = 1'b0;
  logic            in_i_valid;
  logic            in_i_ready;
  logic [DW-1:0]   in_i_data;
  logic [SW-1:0]   in_i_strb;
  logic            a_o_valid, a_o_ready;
  logic [DW-1:0]   a_o_data;
  logic [SW-1:0]   a_o_strb;
  logic            b_o_valid, b_o_ready;
  logic [DW-1:0]   b_o_data;
  logic [SW-1:0]   b_o_strb;
  logic            c_o_valid, c_o_ready;
  logic [DW-1:0]   c_o_data;
  logic [SW-1:0]   c_o_strb;
  ctrl_splitter_t  ctrl;
  flags_splitter_t flags_o;
  splitter_state_t dbg_state_o;

  mac_operand_splitter dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .test_mode_i (test_mode_i),
    .in_i_valid  (in_i_valid),
    .in_i_ready  (in_i_ready),
    .in_i_data   (in_i_data),
    .in_i_strb   (in_i_strb),
    .a_o_valid   (a_o_valid),
    .a_o_ready   (a_o_ready),
    .a_o_data    (a_o_data),
    .a_o_strb    (a_o_strb),
    .b_o_valid   (b_o_valid),
    .b_o_ready   (b_o_ready),
    .b_o_data    (b_o_data),
    .b_o_strb    (b_o_strb),
    .c_o_valid   (c_o_valid),
    .c_o_ready   (c_o_ready),
    .c_o_data    (c_o_data),
    .c_o_strb    (c_o_strb),
    .ctrl_i      (ctrl),
    .flags_o     (flags_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0]   exp_c_q[$];
  logic [2*DW-1:0] exp_ab_q[$];
  logic [DW-1:0]   src_q[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (c_o_valid && c_o_ready) begin
        if (exp_c_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL c_unexpected: got c=0x%0h expected no c word", c_o_data);
        end else begin
          chk("c_data", c_o_data, exp_c_q.pop_front());
          chk("c_strb", c_o_strb, {SW{1'b1}});
        end
      end
      if (a_o_valid && a_o_ready && b_o_ready) begin
        if (exp_ab_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL ab_unexpected: got (0x%0h,0x%0h) expected no pair", a_o_data, b_o_data);
        end else begin
          chk("ab_pair", {a_o_data, b_o_data}, exp_ab_q.pop_front());
          chk("ab_strb", {a_o_strb, b_o_strb}, {2*SW{1'b1}});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n;
    n          = 0;
    in_i_valid = 1'b1;
    in_i_data  = d;
    @(negedge clk_i);
    while (!in_i_ready && n < 200) begin
      n++;
      @(negedge clk_i);
    end
    if (!in_i_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: word 0x%0h got no ready, expected ready within 200 cycles", d);
    end
    cycle();
    in_i_valid = 1'b0;
  endtask

  task automatic send_all();
    while (src_q.size() > 0) send(src_q.pop_front());
  endtask

  task automatic start_job(input logic simple, input logic [MAC_CW-1:0] len);
    ctrl.start      = 1'b1;
    ctrl.simple_mul = simple;
    ctrl.len        = len;
    cycle();
    ctrl.start = 1'b0;
  endtask

  task automatic wait_b_phase(input string name);
    int k;
    k = 0;
    while (dbg_state_o != B_PHASE && k < 100) begin
      cycle();
      k++;
    end
    chk(name, dbg_state_o, B_PHASE);
  endtask

  task automatic check_done(input string name, input logic [MAC_CW-1:0] cnt);
    @(negedge clk_i);
    chk({name, "_done"}, {flags_o.busy, flags_o.done}, 2'b11);
    chk({name, "_cnt"}, flags_o.cnt, cnt);
    cycle();
    @(negedge clk_i);
    chk({name, "_idle"}, {flags_o.busy, flags_o.done}, 2'b00);
    cycle();
  endtask

  task automatic push_scalar_1_to_7();
    src_q = '{32'd5, 32'd1, 32'd2, 32'd3, 32'd4, 32'd6, 32'd7};
    exp_c_q.push_back(32'd5);
    exp_ab_q.push_back({32'd1, 32'd2});
    exp_ab_q.push_back({32'd3, 32'd4});
    exp_ab_q.push_back({32'd6, 32'd7});
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] exp_stall;

  initial begin
`ifdef MAC_SPLITTER_STALL_CNT_EN
    exp_stall = 32'd4;
`else
    exp_stall = 32'd0;
`endif
    ctrl        = '0;
    ctrl.enable = 1'b1;
    a_o_ready   = 1'b1;
    b_o_ready   = 1'b1;
    c_o_ready   = 1'b1;
    in_i_valid  = 1'b1;
    in_i_data   = 32'hdead_beef;
    in_i_strb   = {SW{1'b1}};
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // reset state, with a word already offered upstream
    @(negedge clk_i);
    chk("reset_flags", flags_o, '0);
    chk("reset_state", dbg_state_o, IDLE);
    chk("reset_ready", in_i_ready, 1'b0);
    chk("reset_valids", {a_o_valid, b_o_valid, c_o_valid}, 3'b000);
    cycle();
    in_i_valid = 1'b0;

    // 1: scalar product, len=3
    start_job(1'b0, 5'd3);
    push_scalar_1_to_7();
    send_all();
    check_done("t1", 5'd3);

    // 2: simple mult, len=2, no c word expected
    start_job(1'b1, 5'd2);
    src_q = '{32'd9, 32'd8, 32'd7, 32'd6};
    exp_ab_q.push_back({32'd9, 32'd8});
    exp_ab_q.push_back({32'd7, 32'd6});
    send_all();
    check_done("t2", 5'd2);

    // 3: engine backpressure on the first pair for 4 cycles
    a_o_ready = 1'b0;
    start_job(1'b0, 5'd3);
    push_scalar_1_to_7();
    fork
      send_all();
      begin
        wait_b_phase("t3_reach_b");
        for (int i = 0; i < 4; i++) begin
          @(negedge clk_i);
          chk("t3_pair_held", {a_o_data, b_o_data}, {32'd1, 32'd2});
          chk("t3_valid_ready", {a_o_valid, b_o_valid, in_i_ready}, 3'b110);
          cycle();
        end
        a_o_ready = 1'b1;
        @(negedge clk_i);
        chk("t3_stall_cnt", flags_o.stall_cnt, exp_stall);
      end
    join
    check_done("t3", 5'd3);

    // 4: len=0 finishes without consuming input
    in_i_valid = 1'b1;
    in_i_data  = 32'h1234_5678;
    start_job(1'b0, 5'd0);
    @(negedge clk_i);
    chk("t4_done", {flags_o.busy, flags_o.done}, 2'b11);
    chk("t4_no_io", {in_i_ready, a_o_valid, b_o_valid, c_o_valid}, 4'b0000);
    cycle();
    @(negedge clk_i);
    chk("t4_idle", {flags_o.busy, flags_o.done, in_i_ready}, 3'b000);
    cycle();
    in_i_valid = 1'b0;

    // 5: clear after the first pair, with a colliding start; then a fresh job
    start_job(1'b0, 5'd3);
    src_q = '{32'd5, 32'd1, 32'd2};
    exp_c_q.push_back(32'd5);
    exp_ab_q.push_back({32'd1, 32'd2});
    send_all();
    @(negedge clk_i);
    chk("t5_cnt_before", flags_o.cnt, 5'd1);
    cycle();
    ctrl.clear = 1'b1;
    ctrl.start = 1'b1;
    ctrl.len   = 5'd2;
    cycle();
    ctrl.clear = 1'b0;
    ctrl.start = 1'b0;
    @(negedge clk_i);
    chk("t5_cleared", {flags_o.busy, flags_o.done, flags_o.cnt}, '0);
    chk("t5_state", dbg_state_o, IDLE);
    cycle();
    start_job(1'b0, 5'd1);
    src_q = '{32'd10, 32'd11, 32'd12};
    exp_c_q.push_back(32'd10);
    exp_ab_q.push_back({32'd11, 32'd12});
    send_all();
    check_done("t5", 5'd1);

    // 6: enable dropped for 3 cycles while a pair is pending
    start_job(1'b0, 5'd1);
    src_q = '{32'd20, 32'd21, 32'd22};
    exp_c_q.push_back(32'd20);
    exp_ab_q.push_back({32'd21, 32'd22});
    fork
      send_all();
      begin
        wait_b_phase("t6_reach_b");
        ctrl.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk_i);
          chk("t6_frozen_io", {a_o_valid, b_o_valid, c_o_valid, in_i_ready}, 4'b0000);
          chk("t6_state_kept", dbg_state_o, B_PHASE);
          chk("t6_a_kept", a_o_data, 32'd21);
          cycle();
        end
        ctrl.enable = 1'b1;
      end
    join
    check_done("t6", 5'd1);

    chk("exp_c_drained", exp_c_q.size(), 0);
    chk("exp_ab_drained", exp_ab_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
